// File: rtl/apb_req_arb.sv
// apb_req_arb: round-robin arbiter sharing one APB4 completer port among NUM_REQ requesters, with an ACCESS watchdog.
// Ports: axilite_clk / axilite_rst (sync, active-high); s_psel/s_penable/s_pwrite and flattened s_paddr/s_pwdata/s_pstrb/s_pprot
// per requester (slice i at [i*W +: W]); s_pready one-hot completion pulse with shared s_prdata/s_pslverr; m_* shared
// completer port; busy = transfer in flight; gnt_idx = current or last grant; tmo_cnt = saturating count of watchdog terminations.
module apb_req_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          axilite_clk,
  input  logic                          axilite_rst,
  input  logic [NUM_REQ-1:0]            s_psel,
  input  logic [NUM_REQ-1:0]            s_penable,
  input  logic [NUM_REQ-1:0]            s_pwrite,
  input  logic [NUM_REQ*ADDR_W-1:0]     s_paddr,
  input  logic [NUM_REQ*DATA_W-1:0]     s_pwdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   s_pstrb,
  input  logic [NUM_REQ*3-1:0]          s_pprot,
  output logic [NUM_REQ-1:0]            s_pready,
  output logic [DATA_W-1:0]             s_prdata,
  output logic                          s_pslverr,
  output logic                          m_psel,
  output logic                          m_penable,
  output logic                          m_pwrite,
  output logic [ADDR_W-1:0]             m_paddr,
  output logic [DATA_W-1:0]             m_pwdata,
  output logic [DATA_W/8-1:0]           m_pstrb,
  output logic [2:0]                    m_pprot,
  input  logic                          m_pready,
  input  logic                          m_pslverr,
  input  logic [DATA_W-1:0]             m_prdata,
  output logic                          busy,
  output logic [2:0]                    gnt_idx,
  output logic [15:0]                   tmo_cnt
);
  localparam int STRB_W = DATA_W/8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [2:0] rr_ptr, pick;
  logic [3:0] idx;
  logic [7:0] req;
  logic any, wd_done, done;
  logic [15:0] wd_cnt;
  logic g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_strb;
  logic [2:0] g_prot;
  // Scan offsets from high to low so the last hit, i.e. the lowest offset from rr_ptr, wins.
  always_comb begin
    req = 8'(s_psel);
    any = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 4'(rr_ptr) + 4'(k);
      idx = idx >= 4'(NUM_REQ) ? idx - 4'(NUM_REQ) : idx;
      if (req[idx[2:0]]) begin
        any = 1'b1;
        pick = idx[2:0];
      end
    end
  end
  always_comb begin
    g_wr = 1'b0;
    g_addr = '0;
    g_wdata = '0;
    g_strb = '0;
    g_prot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == 3'(k)) begin
        g_wr = s_pwrite[k];
        g_addr = s_paddr[k*ADDR_W +: ADDR_W];
        g_wdata = s_pwdata[k*DATA_W +: DATA_W];
        g_strb = s_pstrb[k*STRB_W +: STRB_W];
        g_prot = s_pprot[k*3 +: 3];
      end
    end
  end
  assign wd_done = wd_cnt == 16'(TIMEOUT - 1);
  assign done = state == ACCESS && (m_pready || wd_done);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE   ? (any ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt_idx <= '0;
      tmo_cnt <= '0;
      wd_cnt <= '0;
      m_psel <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite <= 1'b0;
      m_paddr <= '0;
      m_pwdata <= '0;
      m_pstrb <= '0;
      m_pprot <= '0;
      s_pready <= '0;
      s_prdata <= '0;
      s_pslverr <= 1'b0;
    end else begin
      state <= state_n;
      s_pready <= '0;
      wd_cnt <= '0;
      if (state == IDLE && any) begin
        m_psel <= 1'b1;
        m_pwrite <= g_wr;
        m_paddr <= g_addr;
        m_pwdata <= g_wdata;
        m_pstrb <= g_strb;
        m_pprot <= g_prot;
        gnt_idx <= pick;
        rr_ptr <= pick == 3'(NUM_REQ - 1) ? 3'd0 : pick + 3'd1;
      end
      if (state == SETUP) m_penable <= 1'b1;
      if (state == ACCESS) wd_cnt <= wd_cnt + 16'd1;
      // A real response beats the watchdog when both land in the same cycle.
      if (done) begin
        m_psel <= 1'b0;
        m_penable <= 1'b0;
        s_pready <= NUM_REQ'(1) << gnt_idx;
        s_prdata <= m_pready && !m_pwrite ? m_prdata : '0;
        s_pslverr <= m_pready ? m_pslverr : 1'b1;
        if (!m_pready && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
endmodule
